// File: rtl/arp_eth_tx.sv
// ARP frame transmitter: latches ARP fields, presents an Ethernet header and streams the 28-byte ARP body on AXI-Stream.
// Define ARP_ETH_TX_PAD_EN to zero-pad the payload to the 46-byte Ethernet minimum.
`timescale 1ns/1ps
module arp_eth_tx #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  s_frame_valid,
    output logic                  s_frame_ready,
    input  logic [47:0]           s_eth_dest_mac,
    input  logic [47:0]           s_eth_src_mac,
    input  logic [15:0]           s_eth_type,
    input  logic [15:0]           s_arp_htype,
    input  logic [15:0]           s_arp_ptype,
    input  logic [7:0]            s_arp_hlen,
    input  logic [7:0]            s_arp_plen,
    input  logic [15:0]           s_arp_oper,
    input  logic [47:0]           s_arp_sha,
    input  logic [31:0]           s_arp_spa,
    input  logic [47:0]           s_arp_tha,
    input  logic [31:0]           s_arp_tpa,

    output logic                  m_eth_hdr_valid,
    input  logic                  m_eth_hdr_ready,
    output logic [47:0]           m_eth_dest_mac,
    output logic [47:0]           m_eth_src_mac,
    output logic [15:0]           m_eth_type,

    output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
    output logic                  m_eth_payload_axis_tvalid,
    input  logic                  m_eth_payload_axis_tready,
    output logic                  m_eth_payload_axis_tlast,
    output logic                  m_eth_payload_axis_tuser,

    output logic                  busy
);

`ifdef ARP_ETH_TX_PAD_EN
    localparam int PAYLOAD_LEN = 46;
`else
    localparam int PAYLOAD_LEN = 28;
`endif
    localparam int FIELD_BYTES = 28;
    localparam int NUM_WORDS   = (PAYLOAD_LEN + KEEP_WIDTH - 1) / KEEP_WIDTH;
    localparam int PTR_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BUF_W       = NUM_WORDS * DATA_WIDTH;
    localparam int LAST_LANES  = ((PAYLOAD_LEN - 1) % KEEP_WIDTH) + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT_HDR
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     r_rst_done;
    logic                     r_hdr_valid;
    logic [PTR_W-1:0]         r_ptr;
    logic [FIELD_BYTES*8-1:0] r_fields;
    logic [47:0]              r_dest_mac;
    logic [47:0]              r_src_mac;
    logic [15:0]              r_eth_type;

    logic                     w_accept;
    logic                     w_xfer;
    logic                     w_last_word;
    logic                     w_final_xfer;
    logic                     w_hdr_done;
    logic [BUF_W-1:0]         w_buf;
    logic [KEEP_WIDTH-1:0]    w_keep_last;

    assign w_accept     = s_frame_valid && s_frame_ready;
    assign w_xfer       = m_eth_payload_axis_tvalid && m_eth_payload_axis_tready;
    assign w_last_word  = (r_ptr == LAST_PTR);
    assign w_final_xfer = w_xfer && w_last_word;
    // Header counts as done if it already left or leaves on this very edge.
    assign w_hdr_done   = !r_hdr_valid || m_eth_hdr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_final_xfer) begin
                    w_state_next = w_hdr_done ? ST_IDLE : ST_WAIT_HDR;
                end
            end
            ST_WAIT_HDR: begin
                if (m_eth_hdr_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_done  <= 1'b0;
            r_hdr_valid <= 1'b0;
            r_ptr       <= '0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_accept) begin
                r_hdr_valid <= 1'b1;
            end else if (m_eth_hdr_ready) begin
                r_hdr_valid <= 1'b0;
            end
            if (w_xfer) begin
                r_ptr <= w_last_word ? '0 : r_ptr + PTR_W'(1);
            end
        end
    end

    // Datapath holds the latched frame; no reset needed since valids gate it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_dest_mac <= s_eth_dest_mac;
            r_src_mac  <= s_eth_src_mac;
            r_eth_type <= s_eth_type;
            r_fields   <= {s_arp_htype, s_arp_ptype, s_arp_hlen, s_arp_plen, s_arp_oper,
                           s_arp_sha, s_arp_spa, s_arp_tha, s_arp_tpa};
        end
    end

    // Byte n of the body sits in lane order at w_buf[n*8 +: 8]; pad and unused lanes stay 0.
    always_comb begin
        w_buf = '0;
        for (int n = 0; n < FIELD_BYTES; n++) begin
            w_buf[n*8 +: 8] = r_fields[(FIELD_BYTES-1-n)*8 +: 8];
        end
    end

    always_comb begin
        m_eth_payload_axis_tdata = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (r_ptr == PTR_W'(w)) begin
                m_eth_payload_axis_tdata = w_buf[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_keep_last = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            w_keep_last[i] = (i < LAST_LANES);
        end
    end

    assign m_eth_payload_axis_tkeep  = (KEEP_ENABLE == 0 || !w_last_word) ? '1 : w_keep_last;
    assign m_eth_payload_axis_tvalid = (r_state == ST_WRITE);
    assign m_eth_payload_axis_tlast  = m_eth_payload_axis_tvalid && w_last_word;
    assign m_eth_payload_axis_tuser  = 1'b0;
    assign busy                      = (r_state == ST_WRITE);

    assign s_frame_ready   = (r_state == ST_IDLE) && r_rst_done;
    assign m_eth_hdr_valid = r_hdr_valid;
    assign m_eth_dest_mac  = r_dest_mac;
    assign m_eth_src_mac   = r_src_mac;
    assign m_eth_type      = r_eth_type;

endmodule

// File: tb/tb_arp_eth_tx.sv
// Directed bench for arp_eth_tx: an 8-bit and a 64-bit instance share the same stimulus.
`timescale 1ns/1ps
module tb_arp_eth_tx;

`ifdef ARP_ETH_TX_PAD_EN
    localparam int LA = 46;
    localparam int NWB = 6;
    localparam logic [7:0] LASTK = 8'h3F;
`else
    localparam int LA = 28;
    localparam int NWB = 4;
    localparam logic [7:0] LASTK = 8'h0F;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s_frame_valid = 1'b0;
    logic [47:0] s_eth_dest_mac = '0;
    logic [47:0] s_eth_src_mac = 48'h5A0102030405;
    logic [15:0] s_eth_type = 16'h0806;
    logic [15:0] s_arp_htype = 16'h0001;
    logic [15:0] s_arp_ptype = 16'h0800;
    logic [7:0]  s_arp_hlen = 8'h06;
    logic [7:0]  s_arp_plen = 8'h04;
    logic [15:0] s_arp_oper = 16'h0001;
    logic [47:0] s_arp_sha = 48'h5A0102030405;
    logic [31:0] s_arp_spa = 32'hC0A80164;
    logic [47:0] s_arp_tha = 48'h0;
    logic [31:0] s_arp_tpa = 32'hC0A80101;
    logic        hdr_ready = 1'b1;
    logic        tready = 1'b1;

    logic        a_ready, a_hdr_valid, a_tvalid, a_tlast, a_tuser, a_busy;
    logic [47:0] a_dmac, a_smac;
    logic [15:0] a_type;
    logic [7:0]  a_tdata;
    logic [0:0]  a_tkeep;
    logic        b_ready, b_hdr_valid, b_tvalid, b_tlast, b_tuser, b_busy;
    logic [47:0] b_dmac, b_smac;
    logic [15:0] b_type;
    logic [63:0] b_tdata;
    logic [7:0]  b_tkeep;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_b [46];

    arp_eth_tx #(.DATA_WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_frame_valid(s_frame_valid), .s_frame_ready(a_ready),
        .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
        .s_arp_htype(s_arp_htype), .s_arp_ptype(s_arp_ptype), .s_arp_hlen(s_arp_hlen),
        .s_arp_plen(s_arp_plen), .s_arp_oper(s_arp_oper), .s_arp_sha(s_arp_sha),
        .s_arp_spa(s_arp_spa), .s_arp_tha(s_arp_tha), .s_arp_tpa(s_arp_tpa),
        .m_eth_hdr_valid(a_hdr_valid), .m_eth_hdr_ready(hdr_ready),
        .m_eth_dest_mac(a_dmac), .m_eth_src_mac(a_smac), .m_eth_type(a_type),
        .m_eth_payload_axis_tdata(a_tdata), .m_eth_payload_axis_tkeep(a_tkeep),
        .m_eth_payload_axis_tvalid(a_tvalid), .m_eth_payload_axis_tready(tready),
        .m_eth_payload_axis_tlast(a_tlast), .m_eth_payload_axis_tuser(a_tuser),
        .busy(a_busy)
    );

    arp_eth_tx #(.DATA_WIDTH(64)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_frame_valid(s_frame_valid), .s_frame_ready(b_ready),
        .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
        .s_arp_htype(s_arp_htype), .s_arp_ptype(s_arp_ptype), .s_arp_hlen(s_arp_hlen),
        .s_arp_plen(s_arp_plen), .s_arp_oper(s_arp_oper), .s_arp_sha(s_arp_sha),
        .s_arp_spa(s_arp_spa), .s_arp_tha(s_arp_tha), .s_arp_tpa(s_arp_tpa),
        .m_eth_hdr_valid(b_hdr_valid), .m_eth_hdr_ready(hdr_ready),
        .m_eth_dest_mac(b_dmac), .m_eth_src_mac(b_smac), .m_eth_type(b_type),
        .m_eth_payload_axis_tdata(b_tdata), .m_eth_payload_axis_tkeep(b_tkeep),
        .m_eth_payload_axis_tvalid(b_tvalid), .m_eth_payload_axis_tready(tready),
        .m_eth_payload_axis_tlast(b_tlast), .m_eth_payload_axis_tuser(b_tuser),
        .busy(b_busy)
    );

    function automatic logic [63:0] exp_word(input int w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            if (w*8 + i < 46) v[i*8 +: 8] = exp_b[w*8 + i];
        end
        return v;
    endfunction

    // Returns at accept edge + 1ns.
    task automatic send_frame(input logic [47:0] dmac);
        int tries;
        s_eth_dest_mac = dmac;
        s_frame_valid = 1'b1;
        tries = 0;
        while (!(a_ready && b_ready) && tries < 20) begin
            @(posedge clk); #1;
            tries++;
        end
        checks++;
        if (tries >= 20) begin
            errors++;
            $display("FAIL send_frame_timeout ready a=%0b b=%0b required 1", a_ready, b_ready);
        end
        @(posedge clk); #1;
        s_frame_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({a_ready, a_hdr_valid, a_tvalid, a_tlast, a_busy, a_tuser} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b required 000000",
                     {a_ready, a_hdr_valid, a_tvalid, a_tlast, a_busy, a_tuser});
        end
        checks++;
        if ({b_ready, b_hdr_valid, b_tvalid, b_busy} !== 4'b0) begin
            errors++;
            $display("FAIL reset_outputs_b got %b required 0000", {b_ready, b_hdr_valid, b_tvalid, b_busy});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release got a=%b b=%b required 1", a_ready, b_ready);
        end
    endtask

    task automatic test_payload(input logic [47:0] dmac);
        tready = 1'b1;
        hdr_ready = 1'b1;
        send_frame(dmac);
        checks++;
        if (a_hdr_valid !== 1'b1 || a_dmac !== dmac || a_smac !== 48'h5A0102030405 || a_type !== 16'h0806) begin
            errors++;
            $display("FAIL header got v=%b d=%h s=%h t=%h required v=1 d=%h s=5a0102030405 t=0806",
                     a_hdr_valid, a_dmac, a_smac, a_type, dmac);
        end
        checks++;
        if (a_ready !== 1'b0 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_accept got ready=%b busy=%b required 0 1", a_ready, a_busy);
        end
        for (int k = 0; k < LA; k++) begin
            checks++;
            if (a_tvalid !== 1'b1 || a_tdata !== exp_b[k] || a_tlast !== (k == LA-1) || a_tkeep !== 1'b1) begin
                errors++;
                $display("FAIL a_word%0d got v=%b d=%h l=%b k=%b required v=1 d=%h l=%b k=1",
                         k, a_tvalid, a_tdata, a_tlast, a_tkeep, exp_b[k], (k == LA-1));
            end
            if (k < NWB) begin
                checks++;
                if (b_tvalid !== 1'b1 || b_tdata !== exp_word(k) || b_tlast !== (k == NWB-1) ||
                    b_tkeep !== ((k == NWB-1) ? LASTK : 8'hFF)) begin
                    errors++;
                    $display("FAIL b_word%0d got v=%b d=%h l=%b k=%h required v=1 d=%h l=%b k=%h",
                             k, b_tvalid, b_tdata, b_tlast, b_tkeep, exp_word(k), (k == NWB-1),
                             (k == NWB-1) ? LASTK : 8'hFF);
                end
            end else if (k == NWB) begin
                checks++;
                if (b_tvalid !== 1'b0 || b_busy !== 1'b0 || b_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b_done got v=%b busy=%b ready=%b required 0 0 1", b_tvalid, b_busy, b_ready);
                end
            end
            if (k == 1) begin
                checks++;
                if (a_hdr_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL hdr_drop got %b required 0", a_hdr_valid);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (a_tvalid !== 1'b0 || a_busy !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL a_done got v=%b busy=%b ready=%b required 0 0 1", a_tvalid, a_busy, a_ready);
        end
    endtask

    task automatic test_stall;
        int ka, kb, cyc;
        tready = 1'b0;
        hdr_ready = 1'b0;
        send_frame(48'h020000000001);
        ka = 0; kb = 0; cyc = 0;
        while (!(ka == LA && kb == NWB) && cyc < 200) begin
            tready = cyc[0];
            if (ka < LA) begin
                checks++;
                if (a_tvalid !== 1'b1 || a_tdata !== exp_b[ka] || a_tlast !== (ka == LA-1)) begin
                    errors++;
                    $display("FAIL stall_a byte%0d got v=%b d=%h l=%b required v=1 d=%h",
                             ka, a_tvalid, a_tdata, a_tlast, exp_b[ka]);
                end
                if (a_tvalid && tready) ka++;
            end
            if (kb < NWB) begin
                checks++;
                if (b_tvalid !== 1'b1 || b_tdata !== exp_word(kb) ||
                    b_tkeep !== ((kb == NWB-1) ? LASTK : 8'hFF)) begin
                    errors++;
                    $display("FAIL stall_b word%0d got v=%b d=%h k=%h required v=1 d=%h",
                             kb, b_tvalid, b_tdata, b_tkeep, exp_word(kb));
                end
                if (b_tvalid && tready) kb++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL stall_timeout got a=%0d b=%0d required %0d %0d", ka, kb, LA, NWB);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_ready !== 1'b0 || a_busy !== 1'b0 || a_tvalid !== 1'b0 || a_hdr_valid !== 1'b1 ||
                b_ready !== 1'b0 || b_hdr_valid !== 1'b1) begin
                errors++;
                $display("FAIL wait_hdr got ready=%b busy=%b v=%b hv=%b b_ready=%b b_hv=%b required 0 0 0 1 0 1",
                         a_ready, a_busy, a_tvalid, a_hdr_valid, b_ready, b_hdr_valid);
            end
            @(posedge clk); #1;
        end
        hdr_ready = 1'b1;
        tready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_hdr_valid !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL hdr_release got hv=%b ready=%b b_ready=%b required 0 1 1", a_hdr_valid, a_ready, b_ready);
        end
    endtask

    task automatic test_reset_midframe;
        tready = 1'b1;
        hdr_ready = 1'b0;
        send_frame(48'h020000000001);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (a_tdata !== exp_b[10]) begin
            errors++;
            $display("FAIL pre_reset_byte got %h required %h", a_tdata, exp_b[10]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_ready, a_hdr_valid, a_tvalid, a_tlast, a_busy, b_tvalid, b_hdr_valid} !== 7'b0) begin
            errors++;
            $display("FAIL midframe_reset got %b required 0000000",
                     {a_ready, a_hdr_valid, a_tvalid, a_tlast, a_busy, b_tvalid, b_hdr_valid});
        end
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_ready !== 1'b1 || a_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_midreset got ready=%b v=%b required 1 0", a_ready, a_tvalid);
        end
        test_payload(48'h0A0B0C0D0E0F);
    endtask

    initial begin
        exp_b = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
                  8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                  8'hC0, 8'hA8, 8'h01, 8'h64,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'hC0, 8'hA8, 8'h01, 8'h01,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        test_reset;
        test_payload(48'h020000000001);
        test_stall;
        test_reset_midframe;
        test_payload(48'hFFFFFFFFFFFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
